stack_arbiter: RTL and testbench

Sequencing controller that shares one hardware LIFO stack (sync active-high reset, push/pop/din/dout, empty/full/error flags, registered pop data) between two requesters, e.g. the return-address unit and a spill/debug port. It round-robin arbitrates requests and pre-checks full/empty so illegal operations never reach the stack. It issues exactly one push or pop pulse per accepted request and returns a registered response to the owning requester. It also owns the stack's reset: initialisation after system reset and software flush.

---
 rtl/stack_arb_pkg.sv | 18 +
 rtl/stack_arbiter_if.sv | 23 ++
 rtl/rr_arbiter2.sv | 28 ++
 rtl/stack_arbiter.sv | 116 +++++++++++
 tb/tb_stack_arbiter.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/stack_arb_pkg.sv
// Shared types and constants for the two-requester LIFO stack sequencer.
package stack_arb_pkg;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_CMD,
    S_RSP,
    S_FLUSH
  } state_t;

  localparam logic OP_PUSH = 1'b1;
  localparam logic OP_POP  = 1'b0;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/stack_arbiter_if.sv
// Bus between the sequencer (master) and the hardware LIFO stack (slave).
interface stack_arbiter_if #(
  parameter int DW = 32
);
  logic          stk_rst;
  logic          stk_push;
  logic          stk_pop;
  logic [DW-1:0] stk_din;
  logic [DW-1:0] stk_dout;
  logic          stk_empty;
  logic          stk_full;
  logic          stk_error;

  modport master (
    output stk_rst, stk_push, stk_pop, stk_din,
    input  stk_dout, stk_empty, stk_full, stk_error
  );

  modport slave (
    input  stk_rst, stk_push, stk_pop, stk_din,
    output stk_dout, stk_empty, stk_full, stk_error
  );
endinterface

// File: rtl/rr_arbiter2.sv
// Two-input round-robin grant; history advances only when a grant is taken.
module rr_arbiter2
  import stack_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] grant
);

  logic last_grant;

  always_comb begin
    grant = '0;
    if (en) begin
      if (req == 2'b11) grant = (last_grant == REQ1) ? 2'b01 : 2'b10;
      else              grant = req;
    end
  end

  // Requests are held until ready, so any grant is an accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       last_grant <= REQ1;
    else if (|grant)  last_grant <= grant[1];
  end

endmodule

// File: rtl/stack_arbiter.sv
// Shares one LIFO stack between two requesters with full/empty precheck,
// one stack pulse per accepted op and a registered response pulse.
module stack_arbiter
  import stack_arb_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          r0_valid,
  input  logic          r0_op,
  input  logic [DW-1:0] r0_data,
  output logic          r0_ready,
  output logic          r0_rsp_valid,
  input  logic          r1_valid,
  input  logic          r1_op,
  input  logic [DW-1:0] r1_data,
  output logic          r1_ready,
  output logic          r1_rsp_valid,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_err,
  output logic          busy,
  stack_arbiter_if.master stk
);

  state_t        state, state_d;
  logic          pend_flush, flush_req;
  logic          op_q, id_q, pre_err;
  logic [DW-1:0] data_q;
  logic [1:0]    grant;
  logic          arb_en, accept, g_id, g_op, g_err;
  logic [DW-1:0] g_data;

  assign flush_req = pend_flush | flush;
  assign arb_en    = (state == S_IDLE) && !flush_req;

  rr_arbiter2 u_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .req   ({r1_valid, r0_valid}),
    .en    (arb_en),
    .grant (grant)
  );

  assign accept = |grant;
  assign g_id   = grant[1];
  assign g_op   = g_id ? r1_op   : r0_op;
  assign g_data = g_id ? r1_data : r0_data;
  assign g_err  = (g_op == OP_PUSH) ? stk.stk_full : stk.stk_empty;

  always_comb begin
    state_d = state;
    case (state)
      S_INIT:  state_d = S_IDLE;
      S_IDLE: begin
        if (flush_req)   state_d = S_FLUSH;
        else if (accept) state_d = g_err ? S_RSP : S_CMD;
      end
      S_CMD:   state_d = S_RSP;
      S_RSP:   state_d = S_IDLE;
      S_FLUSH: state_d = S_IDLE;
      default: state_d = S_INIT;
    endcase
  end

  // INIT is the reset state, so level outputs are qualified by rst_n to stay 0 while held.
  always_comb begin
    r0_ready     = grant[0];
    r1_ready     = grant[1];
    stk.stk_push = (state == S_CMD) && (op_q == OP_PUSH);
    stk.stk_pop  = (state == S_CMD) && (op_q == OP_POP);
    stk.stk_rst  = rst_n && ((state == S_INIT) || (state == S_FLUSH));
    stk.stk_din  = data_q;
    busy         = rst_n && (state != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_INIT;
      pend_flush   <= 1'b0;
      op_q         <= OP_POP;
      id_q         <= REQ0;
      pre_err      <= 1'b0;
      data_q       <= '0;
      rsp_data     <= '0;
      rsp_err      <= 1'b0;
      r0_rsp_valid <= 1'b0;
      r1_rsp_valid <= 1'b0;
    end else begin
      state <= state_d;

      if (state == S_IDLE && flush_req) pend_flush <= 1'b0;
      else if (flush)                   pend_flush <= 1'b1;

      if (accept) begin
        op_q    <= g_op;
        data_q  <= g_data;
        id_q    <= g_id;
        pre_err <= g_err;
      end

      rsp_data     <= '0;
      rsp_err      <= 1'b0;
      r0_rsp_valid <= 1'b0;
      r1_rsp_valid <= 1'b0;
      if (state == S_RSP) begin
        rsp_data     <= (op_q == OP_POP && !pre_err && !stk.stk_error) ? stk.stk_dout : '0;
        rsp_err      <= pre_err | (!pre_err & stk.stk_error);
        r0_rsp_valid <= (id_q == REQ0);
        r1_rsp_valid <= (id_q == REQ1);
      end
    end
  end

endmodule

// File: tb/tb_stack_arbiter.sv
// Directed self-checking bench for stack_arbiter with a 4-entry behavioural stack (full at 3).
module tb_stack_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        r0_valid, r0_op, r0_ready, r0_rsp_valid;
  logic [31:0] r0_data;
  logic        r1_valid, r1_op, r1_ready, r1_rsp_valid;
  logic [31:0] r1_data;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int edges = 0;

  stack_arbiter_if #(.DW(32)) sif ();

  stack_arbiter #(.DW(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .r0_valid     (r0_valid),
    .r0_op        (r0_op),
    .r0_data      (r0_data),
    .r0_ready     (r0_ready),
    .r0_rsp_valid (r0_rsp_valid),
    .r1_valid     (r1_valid),
    .r1_op        (r1_op),
    .r1_data      (r1_data),
    .r1_ready     (r1_ready),
    .r1_rsp_valid (r1_rsp_valid),
    .rsp_data     (rsp_data),
    .rsp_err      (rsp_err),
    .busy         (busy),
    .stk          (sif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edges++;

  // Behavioural stack: sync active-high reset, registered pop data.
  logic [31:0] mem [4];
  int          cnt   = 0;
  logic [31:0] s_dout = '0;
  logic        s_err  = 1'b0;
  assign sif.stk_dout  = s_dout;
  assign sif.stk_error = s_err;
  assign sif.stk_empty = (cnt == 0);
  assign sif.stk_full  = (cnt == 3);

  always @(posedge clk) begin
    if (sif.stk_rst) begin
      cnt <= 0; s_dout <= '0; s_err <= 1'b0;
    end else if (sif.stk_push) begin
      if (cnt == 3) s_err <= 1'b1;
      else begin mem[cnt] <= sif.stk_din; cnt <= cnt + 1; s_err <= 1'b0; end
    end else if (sif.stk_pop) begin
      if (cnt == 0) s_err <= 1'b1;
      else begin s_dout <= mem[cnt-1]; cnt <= cnt - 1; s_err <= 1'b0; end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    r0_valid = 1'b0; r1_valid = 1'b0; flush = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  // Issues one request and captures what the DUT does until its response (bounded).
  task automatic run_op(input bit id, input logic op, input logic [31:0] d,
                        output logic [31:0] rdata, output logic rerr, output int lat,
                        output int npush, output int npop, output logic [31:0] din_seen,
                        output int nother);
    int e0;
    bit acc, got;
    rdata = '0; rerr = 1'b0; lat = -1; npush = 0; npop = 0; din_seen = '0; nother = 0;
    acc = 1'b0; got = 1'b0;
    @(negedge clk);
    if (id) begin r1_valid = 1'b1; r1_op = op; r1_data = d; end
    else    begin r0_valid = 1'b1; r0_op = op; r0_data = d; end
    for (int i = 0; i < 20; i++) begin
      #1;
      if ((id ? r1_ready : r0_ready) === 1'b1) begin acc = 1'b1; break; end
      @(negedge clk);
    end
    e0 = edges;
    if (!acc) begin
      r0_valid = 1'b0; r1_valid = 1'b0;
      return;
    end
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (id) r1_valid = 1'b0; else r0_valid = 1'b0;
      if (sif.stk_push === 1'b1) begin npush++; din_seen = sif.stk_din; end
      if (sif.stk_pop === 1'b1) npop++;
      if ((id ? r0_rsp_valid : r1_rsp_valid) === 1'b1) nother++;
      if ((id ? r1_rsp_valid : r0_rsp_valid) === 1'b1) begin
        got = 1'b1; lat = edges - e0; rdata = rsp_data; rerr = rsp_err;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0;
    r0_valid = 1'b0; r0_op = 1'b0; r0_data = '0;
    r1_valid = 1'b0; r1_op = 1'b0; r1_data = '0;
    repeat (2) @(negedge clk);
    total++;
    if ({sif.stk_rst, sif.stk_push, sif.stk_pop, busy, r0_ready, r1_ready, r0_rsp_valid, r1_rsp_valid, rsp_err} !== 9'b0) begin
      bad++; $display("FAIL reset_ctrl: got %b want 000000000",
        {sif.stk_rst, sif.stk_push, sif.stk_pop, busy, r0_ready, r1_ready, r0_rsp_valid, r1_rsp_valid, rsp_err});
    end
    total++;
    if ({sif.stk_din, rsp_data} !== 64'h0) begin
      bad++; $display("FAIL reset_data: got din=%h rsp=%h want 0", sif.stk_din, rsp_data);
    end
    rst_n = 1'b1;
    #1;
    total++;
    if (sif.stk_rst !== 1'b1) begin bad++; $display("FAIL init_rst_on: got %b want 1", sif.stk_rst); end
    @(negedge clk);
    total++;
    if ({sif.stk_rst, busy} !== 2'b00) begin
      bad++; $display("FAIL init_rst_off: got rst,busy=%b want 00", {sif.stk_rst, busy});
    end
  endtask

  task automatic test_push_basic();
    logic [31:0] rd, dn; logic re; int lat, np, npp, no;
    run_op(1'b0, 1'b1, 32'hA5, rd, re, lat, np, npp, dn, no);
    total++; if (lat !== 3) begin bad++; $display("FAIL push_latency: got %0d want 3", lat); end
    total++; if (np !== 1 || npp !== 0) begin bad++; $display("FAIL push_pulses: got push=%0d pop=%0d want 1 0", np, npp); end
    total++; if (dn !== 32'hA5) begin bad++; $display("FAIL push_din: got %h want a5", dn); end
    total++; if (re !== 1'b0 || rd !== 32'h0) begin bad++; $display("FAIL push_rsp: got err=%b data=%h want 0 0", re, rd); end
    total++; if (no !== 0) begin bad++; $display("FAIL push_other_rsp: got %0d want 0", no); end
  endtask

  task automatic test_round_robin();
    int order [3];
    int n = 0, c0 = 0, c1 = 0, both = 0, errs = 0;
    do_reset();
    r0_valid = 1'b1; r0_op = 1'b1; r0_data = 32'h1;
    r1_valid = 1'b1; r1_op = 1'b1; r1_data = 32'h2;
    for (int i = 0; i < 30; i++) begin
      #1;
      if (r0_rsp_valid === 1'b1) c0++;
      if (r1_rsp_valid === 1'b1) c1++;
      if (rsp_err === 1'b1) errs++;
      if (r0_ready === 1'b1 && r1_ready === 1'b1) both++;
      else if (r0_ready === 1'b1 && n < 3) begin order[n] = 0; n++; end
      else if (r1_ready === 1'b1 && n < 3) begin order[n] = 1; n++; end
      @(negedge clk);
      if (n >= 3) begin r0_valid = 1'b0; r1_valid = 1'b0; end
    end
    total++; if (n !== 3) begin bad++; $display("FAIL rr_accepts: got %0d want 3", n); end
    else begin
      total++;
      if (order[0] !== 0 || order[1] !== 1 || order[2] !== 0) begin
        bad++; $display("FAIL rr_order: got %0d%0d%0d want 010", order[0], order[1], order[2]);
      end
    end
    total++; if (c0 !== 2 || c1 !== 1) begin bad++; $display("FAIL rr_rsp_count: got r0=%0d r1=%0d want 2 1", c0, c1); end
    total++; if (both !== 0 || errs !== 0) begin bad++; $display("FAIL rr_clean: got both=%0d err=%0d want 0 0", both, errs); end
  endtask

  task automatic test_full();
    logic [31:0] rd, dn; logic re; int lat, np, npp, no, e = 0;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      run_op(i[0], 1'b1, 32'h100 + i, rd, re, lat, np, npp, dn, no);
      if (re !== 1'b0 || np !== 1 || lat !== 3) e++;
    end
    total++; if (e !== 0) begin bad++; $display("FAIL full_fill: got %0d bad pushes want 0", e); end
    run_op(1'b1, 1'b1, 32'hDEAD, rd, re, lat, np, npp, dn, no);
    total++; if (re !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL full_err: got err=%b data=%h want 1 0", re, rd); end
    total++; if (np !== 0 || npp !== 0) begin bad++; $display("FAIL full_no_push: got push=%0d pop=%0d want 0 0", np, npp); end
    total++; if (lat !== 2) begin bad++; $display("FAIL full_latency: got %0d want 2", lat); end
  endtask

  task automatic test_pop();
    logic [31:0] rd, dn; logic re; int lat, np, npp, no;
    do_reset();
    run_op(1'b0, 1'b0, 32'h0, rd, re, lat, np, npp, dn, no);
    total++; if (re !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL empty_pop: got err=%b data=%h want 1 0", re, rd); end
    total++; if (npp !== 0) begin bad++; $display("FAIL empty_no_pop: got %0d want 0", npp); end
    run_op(1'b0, 1'b1, 32'h11, rd, re, lat, np, npp, dn, no);
    run_op(1'b1, 1'b1, 32'h22, rd, re, lat, np, npp, dn, no);
    run_op(1'b0, 1'b0, 32'h0, rd, re, lat, np, npp, dn, no);
    total++; if (rd !== 32'h22 || re !== 1'b0) begin bad++; $display("FAIL pop1: got data=%h err=%b want 22 0", rd, re); end
    total++; if (npp !== 1 || lat !== 3) begin bad++; $display("FAIL pop1_timing: got pop=%0d lat=%0d want 1 3", npp, lat); end
    run_op(1'b1, 1'b0, 32'h0, rd, re, lat, np, npp, dn, no);
    total++; if (rd !== 32'h11 || re !== 1'b0) begin bad++; $display("FAIL pop2: got data=%h err=%b want 11 0", rd, re); end
  endtask

  task automatic test_flush();
    logic [31:0] rd, dn; logic re; int lat, np, npp, no;
    int rsp_at = -1, rst_at = -1, nrst = 0;
    logic rerr = 1'b1;
    bit acc = 1'b0;
    do_reset();
    @(negedge clk);
    r0_valid = 1'b1; r0_op = 1'b1; r0_data = 32'h33;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (r0_ready === 1'b1) begin acc = 1'b1; break; end
      @(negedge clk);
    end
    @(negedge clk);
    r0_valid = 1'b0; flush = 1'b1;
    total++; if (acc !== 1'b1 || sif.stk_push !== 1'b1) begin
      bad++; $display("FAIL flush_cmd: got acc=%b push=%b want 1 1", acc, sif.stk_push);
    end
    @(negedge clk);
    flush = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (r0_rsp_valid === 1'b1) begin if (rsp_at < 0) rsp_at = i; rerr = rsp_err; end
      if (sif.stk_rst === 1'b1) begin nrst++; if (rst_at < 0) rst_at = i; end
      @(negedge clk);
    end
    total++; if (rsp_at !== 1 || rerr !== 1'b0) begin bad++; $display("FAIL flush_rsp: got at=%0d err=%b want 1 0", rsp_at, rerr); end
    total++; if (rst_at !== 2 || nrst !== 1) begin bad++; $display("FAIL flush_rst: got at=%0d n=%0d want 2 1", rst_at, nrst); end
    run_op(1'b1, 1'b0, 32'h0, rd, re, lat, np, npp, dn, no);
    total++; if (re !== 1'b1 || npp !== 0) begin bad++; $display("FAIL flush_pop: got err=%b pop=%0d want 1 0", re, npp); end
  endtask

  task automatic test_reset_mid_op();
    int nrst = 0, rst_at = -1, rdy_at = -1, c0 = 0, c1 = 0;
    bit acc = 1'b0;
    do_reset();
    @(negedge clk);
    r1_valid = 1'b1; r1_op = 1'b1; r1_data = 32'h44;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (r1_ready === 1'b1) begin acc = 1'b1; break; end
      @(negedge clk);
    end
    @(negedge clk);
    total++; if (acc !== 1'b1 || sif.stk_push !== 1'b1) begin
      bad++; $display("FAIL rmid_cmd: got acc=%b push=%b want 1 1", acc, sif.stk_push);
    end
    rst_n = 1'b0; r1_valid = 1'b0;
    #1;
    total++;
    if ({sif.stk_push, sif.stk_pop, sif.stk_rst, busy, r0_rsp_valid, r1_rsp_valid} !== 6'b0) begin
      bad++; $display("FAIL rmid_outputs: got %b want 000000",
        {sif.stk_push, sif.stk_pop, sif.stk_rst, busy, r0_rsp_valid, r1_rsp_valid});
    end
    @(negedge clk);
    r0_valid = 1'b1; r0_op = 1'b1; r0_data = 32'h55;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (sif.stk_rst === 1'b1) begin nrst++; if (rst_at < 0) rst_at = i; end
      if (r0_ready === 1'b1 && rdy_at < 0) rdy_at = i;
      if (r0_rsp_valid === 1'b1) c0++;
      if (r1_rsp_valid === 1'b1) c1++;
      @(negedge clk);
      if (rdy_at >= 0) r0_valid = 1'b0;
    end
    total++; if (nrst !== 1 || rst_at !== 0) begin bad++; $display("FAIL rmid_init: got n=%0d at=%0d want 1 0", nrst, rst_at); end
    total++; if (rdy_at !== 1) begin bad++; $display("FAIL rmid_ready: got %0d want 1", rdy_at); end
    total++; if (c1 !== 0 || c0 !== 1) begin bad++; $display("FAIL rmid_rsp: got r1=%0d r0=%0d want 0 1", c1, c0); end
  endtask

  initial begin
    test_reset();
    test_push_basic();
    test_round_robin();
    test_full();
    test_pop();
    test_flush();
    test_reset_mid_op();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
